// File: rtl/sram_pkg.sv
// sram_pkg
// Shared types and constants for the 16-bit asynchronous SRAM controller.
// Contents: FSM state enum, SRAM bus widths, default base address,
// word-index width and wait-counter width.
package sram_pkg;

    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_DATA_W       = 16;
    localparam int DEFAULT_BASE_ADDR = 1024;

    // One 32-bit word spans two half-word SRAM locations.
    localparam int WORD_W = SRAM_ADDR_W - 1;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
// Loadable down-counter that times how long each 16-bit half is held
// on the SRAM bus. It is reloaded on entry to LO and again on entry to HI.
// Ports:
//   clk        - clock
//   rst        - synchronous reset, active-low (clears count to 0)
//   load       - load load_value this cycle
//   load_value - WAIT_CYCLES-1, so the held state lasts WAIT_CYCLES cycles
//   last_cycle - terminal count reached (count == 0)
module sram_wait_counter
    import sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             last_cycle
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign last_cycle = (count_q == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Multi-cycle bridge between the MEM pipeline stage and a 16-bit
// asynchronous SRAM. One 32-bit load/store becomes two 16-bit accesses
// (low half, then high half). ready stays low while an access is in flight
// so the pipeline and PC can be frozen with !ready.
//
// Optional feature: define SRAM_READ_BUFFER_EN to add a one-entry read
// buffer (tag, data, valid). A read hitting the buffer completes in IDLE
// with ready high in the same cycle and no SRAM access.
//
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   wr_en, rd_en          - store / load request, held until ready
//   address               - byte address; word = (address - BASE_ADDR) >> 2
//   write_data            - store data
//   read_data             - load result, held until the next read capture
//   ready                 - no access pending, or access completes this cycle
//   SRAM_DQ               - bidirectional SRAM data bus
//   SRAM_ADDR             - SRAM half-word address
//   SRAM_WE_N             - SRAM write enable, active-low
//   SRAM_CE_N/OE_N/UB_N/LB_N - tied low
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access; a request is captured and LO entered
// LO    | low half on the bus for WAIT_CYCLES cycles
// HI    | high half on the bus for WAIT_CYCLES cycles
// DONE  | one cycle with ready high; read_data valid; back to IDLE
module sram_mem_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t state_q, state_d;

    logic                   op_write_q;
    logic [WORD_W-1:0]      word_q;
    logic [31:0]            wdata_q;
    logic [31:0]            read_data_q;

    logic [WORD_W-1:0]      word_in;
    logic                   req;
    logic                   capture;
    logic                   cap_lo;
    logic                   cap_hi;
    logic                   cnt_load;
    logic                   last_cycle;
    logic                   dq_oe;
    logic [SRAM_DATA_W-1:0] dq_out;
    logic                   buf_hit;

    // Subtraction uses all 32 address bits; the >>2 drops the byte offset
    // and the cast keeps the 17-bit word index.
    assign word_in = WORD_W'((address - BASE_ADDR) >> 2);
    assign req     = wr_en | rd_en;

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (WAIT_LOAD),
        .last_cycle (last_cycle)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];
        SRAM_ADDR = {word_q, 1'b0};
        cnt_load  = 1'b0;
        capture   = 1'b0;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_hit) begin
                    ready = 1'b1;
                end else if (req) begin
                    capture  = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = LO;
                end else begin
                    ready = 1'b1;
                end
            end
            LO: begin
                // WE_N and the bus driver switch together so the bus is
                // never released while a write is still enabled.
                if (op_write_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                end
                if (last_cycle) begin
                    cap_lo   = !op_write_q;
                    cnt_load = 1'b1;
                    state_d  = HI;
                end
            end
            HI: begin
                SRAM_ADDR = {word_q, 1'b1};
                dq_out    = wdata_q[31:16];
                if (op_write_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                end
                if (last_cycle) begin
                    cap_hi  = !op_write_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

`ifdef SRAM_READ_BUFFER_EN
    logic              buf_valid_q;
    logic [WORD_W-1:0] buf_tag_q;
    logic [31:0]       buf_data_q;

    // Only a pure read can hit; a simultaneous wr_en makes it a write.
    assign buf_hit = (state_q == IDLE) && rd_en && !wr_en &&
                     buf_valid_q && (buf_tag_q == word_in);

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else if (state_q == DONE) begin
            if (!op_write_q) begin
                buf_valid_q <= 1'b1;
                buf_tag_q   <= word_q;
                buf_data_q  <= read_data_q;
            end else if (buf_valid_q && (buf_tag_q == word_q)) begin
                buf_data_q <= wdata_q;
            end
        end
    end

    assign read_data = buf_hit ? buf_data_q : read_data_q;
`else
    assign buf_hit   = 1'b0;
    assign read_data = read_data_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_write_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            if (capture) begin
                op_write_q <= wr_en;
                word_q     <= word_in;
                wdata_q    <= write_data;
            end
            if (cap_lo) begin
                read_data_q[15:0] <= SRAM_DQ;
            end
            if (cap_hi) begin
                read_data_q[31:16] <= SRAM_DQ;
            end
`ifdef SRAM_READ_BUFFER_EN
            // Keeps read_data stable after a buffer hit, like a full read.
            if (buf_hit) begin
                read_data_q <= buf_data_q;
            end
`endif
        end
    end

    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller
// Scoreboard bench for sram_mem_controller with a behavioural 16-bit SRAM.
// Stimulus pushes expected completions and expected write-bus cycles into
// queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_sram_mem_controller;
    import sram_pkg::*;

    localparam int WAIT = 2;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          low;
    } acc_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;

    int n_checks = 0;
    int n_pass   = 0;
    int low_cnt  = 0;

    acc_t acc_q[$];
    bus_t bus_q[$];

    logic [15:0] mem [0:255];
    logic [17:0] wr_addr_q = '0;
    int          wr_run = 0;

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    // SRAM drives whenever it is not being written (CE/OE tied active).
    assign sram_dq = SRAM_WE_N ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

    // A write commits only once the pulse has been held WAIT cycles at one
    // address, so an access cut short by reset leaves the location untouched.
    always @(posedge clk) begin
        int run_n;
        if (!SRAM_WE_N) begin
            run_n = (wr_run > 0 && SRAM_ADDR == wr_addr_q) ? wr_run + 1 : 1;
            if (run_n == WAIT) mem[SRAM_ADDR[7:0]] <= sram_dq;
            wr_run    <= run_n;
            wr_addr_q <= SRAM_ADDR;
        end else begin
            wr_run <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        bus_t b;
        acc_t a;
        if (!SRAM_WE_N) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_we_low", {14'd0, SRAM_ADDR}, 32'hFFFFFFFF);
            end else begin
                b = bus_q.pop_front();
                chk("bus_addr", {14'd0, SRAM_ADDR}, {14'd0, b.addr});
                chk("bus_data", {16'd0, sram_dq}, {16'd0, b.data});
            end
        end
        if (!rst) begin
            low_cnt = 0;
        end else if (wr_en || rd_en) begin
            if (!ready) begin
                low_cnt++;
            end else if (acc_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                a = acc_q.pop_front();
                chk("ready_low_cycles", low_cnt, a.low);
                chk(a.is_read ? "load_data" : "read_data_held", read_data, a.data);
                low_cnt = 0;
            end
        end
    end

    task automatic push_bus(input logic [17:0] addr, input logic [15:0] data);
        bus_t b;
        b.addr = addr;
        b.data = data;
        bus_q.push_back(b);
    endtask

    task automatic exp_store(input logic [17:0] lo_addr, input logic [31:0] d, input logic [31:0] hold);
        acc_t a;
        for (int i = 0; i < WAIT; i++) push_bus(lo_addr, d[15:0]);
        for (int i = 0; i < WAIT; i++) push_bus(lo_addr + 18'd1, d[31:16]);
        a.is_read = 1'b0;
        a.data    = hold;
        a.low     = 2 * WAIT + 1;
        acc_q.push_back(a);
    endtask

    task automatic exp_load(input logic [31:0] d, input int low);
        acc_t a;
        a.is_read = 1'b1;
        a.data    = d;
        a.low     = low;
        acc_q.push_back(a);
    endtask

    // Leaves the request asserted on return so a following call is back-to-back.
    task automatic do_access(input bit w, input bit r, input logic [31:0] a,
                             input logic [31:0] d, input bit scramble);
        bit done = 1'b0;
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
            else if (scramble && i == 1) begin
                address    = 32'd1024;
                write_data = 32'hFFFFFFFF;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL access_timeout: ready never rose for address 0x%08h", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_we_n", SRAM_WE_N, 1);
        chk("reset_read_data", read_data, 0);
        chk("tied_controls", {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 0);
        @(posedge clk);
        #1;

        exp_store(18'd0, 32'h1234ABCD, 32'h0);
        do_access(1, 0, 32'd1024, 32'h1234ABCD, 0);
        idle();
        exp_load(32'h1234ABCD, 5);
        do_access(0, 1, 32'd1024, 32'h0, 0);
        idle();

        exp_store(18'd2, 32'hDEADBEEF, 32'h1234ABCD);
        do_access(1, 0, 32'd1028, 32'hDEADBEEF, 0);
        idle();
        exp_load(32'hDEADBEEF, 5);
        do_access(0, 1, 32'd1031, 32'h0, 0);
        idle();

        exp_store(18'd4, 32'hCAFEF00D, 32'hDEADBEEF);
        exp_load(32'hCAFEF00D, 5);
        do_access(1, 0, 32'd1032, 32'hCAFEF00D, 0);
        do_access(0, 1, 32'd1032, 32'h0, 0);
        idle();

        // Store aborted by reset in its first HI cycle.
        push_bus(18'd0, 16'hAAAA);
        push_bus(18'd0, 16'hAAAA);
        push_bus(18'd1, 16'h5555);
        wr_en      = 1'b1;
        address    = 32'd1024;
        write_data = 32'h5555AAAA;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_we_n", SRAM_WE_N, 1);
        chk("abort_read_data", read_data, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        exp_load(32'h1234AAAA, 5);
        do_access(0, 1, 32'd1024, 32'h0, 0);
        idle();

        // Both enables high is a write; input changes mid-access are ignored.
        exp_store(18'd6, 32'h11112222, 32'h1234AAAA);
        do_access(1, 1, 32'd1036, 32'h11112222, 1);
        idle();
        exp_load(32'h11112222, 5);
        do_access(0, 1, 32'd1036, 32'h0, 0);
        idle();

`ifdef SRAM_READ_BUFFER_EN
        exp_load(32'h1234AAAA, 5);
        do_access(0, 1, 32'd1024, 32'h0, 0);
        idle();
        exp_load(32'h1234AAAA, 0);
        do_access(0, 1, 32'd1024, 32'h0, 0);
        idle();
        exp_store(18'd0, 32'h0F0F0F0F, 32'h1234AAAA);
        do_access(1, 0, 32'd1024, 32'h0F0F0F0F, 0);
        idle();
        exp_load(32'h0F0F0F0F, 0);
        do_access(0, 1, 32'd1024, 32'h0, 0);
        idle();
`endif

        repeat (3) @(posedge clk);
        chk("pending_completions", acc_q.size(), 0);
        chk("pending_bus_writes", bus_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle controller between the MEM pipeline stage and an external 16-bit asynchronous SRAM.
- Converts one 32-bit load/store into two sequenced 16-bit SRAM accesses.
- Holds ready low for the duration of each access; the top level uses !ready to freeze every pipeline register and the PC.
- Replaces the single-cycle data memory in the MEM stage.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: cycles each 16-bit half is held on the SRAM bus. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- wr_en  in  1  store request, held until ready
- rd_en  in  1  load request, held until ready
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (Val_Rm)
- read_data  out  32  load result
- ready  out  1  high when no access is pending or the current access completes this cycle
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  18  SRAM half-word address
- SRAM_WE_N  out  1  write enable, active-low
- SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0

Behaviour:
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, truncated to 17 bits.
  - SRAM_ADDR = {word, 1'b0} for the low half and {word, 1'b1} for the high half.
  - address[1:0] is ignored.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - Outputs: ready = !(wr_en | rd_en); SRAM_WE_N = 1; SRAM_DQ = Z.
  - On a request, capture the operation, address and write_data, then go to LO.
  - If wr_en and rd_en are both high, the access is a write.
- LO:
  - Lasts WAIT_CYCLES cycles, counted by a wait counter; ready = 0.
  - SRAM_ADDR = low-half address.
  - Write: SRAM_WE_N = 0 and SRAM_DQ = write_data[15:0] for every cycle of the state.
  - Read: SRAM_WE_N = 1, SRAM_DQ = Z; read_data[15:0] is captured from SRAM_DQ on the last cycle.
  - Then go to HI.
- HI:
  - Same as LO, using the high-half address and write_data[31:16] / read_data[31:16].
  - Then go to DONE.
- DONE:
  - Lasts one cycle; ready = 1, SRAM_WE_N = 1, SRAM_DQ = Z.
  - read_data is valid (for reads) and the pipeline advances.
  - Next state is IDLE unconditionally, so a back-to-back request starts one cycle later.
- Latency: ready is low for 2*WAIT_CYCLES+1 cycles (1 IDLE + LO + HI), then high for 1 cycle in DONE. With the default this is 5 low, 1 high.
- read_data holds its value until the next read capture. It is not altered by writes.
- Captured operation, address and data are frozen for the whole access. Input changes mid-access are ignored.
- SRAM_WE_N is never low in the same cycle SRAM_DQ is released. The bus is driven only during LO/HI of a write.
- Reset (rst = 0 at a clock edge), including mid-access:
  - state = IDLE, counter = 0, read_data = 0, SRAM_WE_N = 1, SRAM_DQ = Z.
  - ready follows the IDLE rule. The aborted access is not resumed.
- The controller does not arbitrate; exactly one requester (the MEM stage) drives it.

Optional Feature:
- Macro: SRAM_READ_BUFFER_EN.
- With the macro defined, the controller keeps a one-entry read buffer: tag (17-bit word), 32-bit data, and a valid bit.
  - Read in IDLE whose word matches the tag while valid: hit. ready = 1 combinationally in the same cycle; read_data = buffer data; no SRAM access; state stays IDLE.
  - Completed SRAM read: load the buffer and set valid.
  - Completed write to the tagged word: update the buffer data.
  - Reset clears valid.
- Without the macro, every read runs the full sequence and there is no buffer logic.

Decomposition:
- Shared package sram_pkg holds:
  - state enum (IDLE, LO, HI, DONE);
  - SRAM_ADDR_W = 18 and SRAM_DATA_W = 16;
  - DEFAULT_BASE_ADDR = 1024.
- One sub-module, sram_wait_counter:
  - loadable down-counter with synchronous active-low reset;
  - outputs last_cycle;
  - reused by the LO and HI states.

Test Plan:
- Store 0x1234ABCD at address 1024:
  - SRAM_ADDR 0 receives 0xABCD, then SRAM_ADDR 1 receives 0x1234.
  - SRAM_WE_N is low for 4 cycles total; ready is low 5 cycles, then high 1 cycle.
- Load from 1024 after the store -> read_data = 0x1234ABCD in DONE; SRAM_WE_N stays 1 throughout.
- Store 0xDEADBEEF at 1028, then load from 1031 -> SRAM_ADDR 2/3 used both times; load returns 0xDEADBEEF.
- Back-to-back store then load with requests held -> second access enters LO exactly 2 cycles after DONE. No bus contention: SRAM_DQ is Z before the read samples.
- Assert rst = 0 during HI of a store -> next cycle IDLE, SRAM_WE_N = 1, DQ = Z, read_data = 0. A following load from 1024 shows only the low half was written.
- With SRAM_READ_BUFFER_EN defined:
  - Two consecutive loads from 1024: the second has ready = 1 in its first cycle and no SRAM_ADDR activity.
  - A store of 0x0F0F0F0F to 1024 followed by a load returns 0x0F0F0F0F from the buffer.
